// File: rtl/fine_ctrl_pkg.sv
// Shared types and constants for the fine_ctrl sync arming block.
package fine_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DELAY = 2'd2,
        ST_FIRE  = 2'd3
    } state_t;

    localparam int CTRL_W        = 32;
    localparam int BIT_ARM       = 0;
    localparam int BIT_SW_TRIG   = 1;
    localparam int BIT_CNT_CLR   = 2;
    localparam int EDGE_W        = 3;
    localparam int CHAN_LSB      = 4;
    localparam int CHAN_W        = 4;
    localparam int DELAY_LSB     = 16;
    localparam int DELAY_FIELD_W = 16;
    localparam int DEF_DELAY_W   = 16;
    localparam int DEF_CNT_W     = 16;

endpackage

// File: rtl/fine_ctrl_edge_det.sv
// Rising/falling edge detector: keeps the previous sample of d and compares it with the current one.
module fine_ctrl_edge_det #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         srst,
    input  logic [W-1:0] d,
    output logic [W-1:0] rise,
    output logic [W-1:0] fall
);

    logic [W-1:0] d_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            d_reg <= '0;
        end else begin
            d_reg <= d;
        end
    end

    for (genvar gi = 0; gi < W; gi++) begin : g_bit
        assign rise[gi] = d[gi] & ~d_reg[gi];
        assign fall[gi] = ~d[gi] & d_reg[gi];
    end

endmodule

// File: rtl/fine_ctrl_sync_arm.sv
// Software-armed sync gate: after an arm edge, the next sync event is forwarded once,
// delayed by a latched fine_delay, and counted for readback.
module fine_ctrl_sync_arm
    import fine_ctrl_pkg::*;
#(
    parameter int DELAY_W = DEF_DELAY_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic               user_clk,
    input  logic               user_rst,
    input  logic [31:0]        ctrl_word,
    input  logic               sync_in,
    output logic               sync_out,
    output logic               armed,
    output logic [3:0]         chan_sel,
    output logic [DELAY_W-1:0] fine_delay,
    output logic [CNT_W-1:0]   sync_count
);

    state_t              state_reg;
    logic [CTRL_W-1:0]   ctrl_q_reg;
    logic [DELAY_W-1:0]  cnt_reg;
    logic [EDGE_W-1:0]   ctrl_rise;
    logic [EDGE_W-1:0]   ctrl_fall;
    logic [DELAY_W-1:0]  delay_field;
    logic                arm_rise;
    logic                arm_fall;
    logic                sw_rise;
    logic                clr_rise;
    logic                unused_ctrl;

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            ctrl_q_reg <= '0;
        end else begin
            ctrl_q_reg <= ctrl_word;
        end
    end

    // The detector's internal register is the second ctrl stage; edges compare the two stages.
    fine_ctrl_edge_det #(
        .W(EDGE_W)
    ) u_edge_det (
        .clk  (user_clk),
        .srst (user_rst),
        .d    (ctrl_q_reg[EDGE_W-1:0]),
        .rise (ctrl_rise),
        .fall (ctrl_fall)
    );

    assign arm_rise    = ctrl_rise[BIT_ARM];
    assign arm_fall    = ctrl_fall[BIT_ARM];
    assign sw_rise     = ctrl_rise[BIT_SW_TRIG];
    assign clr_rise    = ctrl_rise[BIT_CNT_CLR];
    assign delay_field = DELAY_W'(ctrl_q_reg[DELAY_LSB +: DELAY_FIELD_W]);
    assign unused_ctrl = &{1'b0, ctrl_fall[BIT_CNT_CLR:BIT_SW_TRIG], ctrl_q_reg[15:8], ctrl_q_reg[3]};

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            state_reg  <= ST_IDLE;
            sync_out   <= 1'b0;
            armed      <= 1'b0;
            chan_sel   <= '0;
            fine_delay <= '0;
            cnt_reg    <= '0;
        end else begin
            sync_out <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (arm_rise) begin
                        state_reg  <= ST_ARMED;
                        armed      <= 1'b1;
                        chan_sel   <= ctrl_q_reg[CHAN_LSB +: CHAN_W];
                        fine_delay <= delay_field;
                    end
                end
                ST_ARMED: begin
                    // Disarm is checked first so it beats a coincident event.
                    if (arm_fall) begin
                        state_reg <= ST_IDLE;
                        armed     <= 1'b0;
                    end else if (sync_in || sw_rise) begin
                        if (fine_delay == '0) begin
                            state_reg <= ST_FIRE;
                            sync_out  <= 1'b1;
                            armed     <= 1'b0;
                        end else begin
                            state_reg <= ST_DELAY;
                            cnt_reg   <= fine_delay;
                        end
                    end
                end
                ST_DELAY: begin
                    cnt_reg <= cnt_reg - 1'b1;
                    if (arm_fall) begin
                        state_reg <= ST_IDLE;
                        armed     <= 1'b0;
                    end else if (cnt_reg == DELAY_W'(1)) begin
                        state_reg <= ST_FIRE;
                        sync_out  <= 1'b1;
                        armed     <= 1'b0;
                    end
                end
                ST_FIRE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    armed     <= 1'b0;
                end
            endcase
        end
    end

    // A clear edge overrides the increment of a coincident FIRE cycle.
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            sync_count <= '0;
        end else if (clr_rise) begin
            sync_count <= '0;
        end else if (state_reg == ST_FIRE) begin
            sync_count <= sync_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_fine_ctrl_sync_arm.sv
// Self-checking bench for fine_ctrl_sync_arm: directed scenarios plus randomized traffic vs a fire-time model.
module tb_fine_ctrl_sync_arm;

    localparam int CNT_W = 8;
    localparam int VEC_W = 2 + 4 + 16 + CNT_W;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       ctrl_word;
    logic              sync_in;
    logic              sync_out;
    logic              armed;
    logic [3:0]        chan_sel;
    logic [15:0]       fine_delay;
    logic [CNT_W-1:0]  sync_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: phase 0 idle, 1 waiting for an event, 2 pulse scheduled at absolute cycle fire_at.
    int               cyc     = 0;
    int               phase   = 0;
    int               fire_at = -10;
    logic [31:0]      c1      = '0;
    logic [31:0]      c2      = '0;
    logic [3:0]       m_chan  = '0;
    logic [15:0]      m_delay = '0;
    logic [CNT_W-1:0] m_count = '0;
    logic             m_sync  = 1'b0;
    logic             m_armed = 1'b0;

    fine_ctrl_sync_arm #(
        .DELAY_W(16),
        .CNT_W  (CNT_W)
    ) dut (
        .user_clk   (clk),
        .user_rst   (rst),
        .ctrl_word  (ctrl_word),
        .sync_in    (sync_in),
        .sync_out   (sync_out),
        .armed      (armed),
        .chan_sel   (chan_sel),
        .fine_delay (fine_delay),
        .sync_count (sync_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [15:0] d, input logic [3:0] ch,
                                       input logic clr, input logic sw, input logic arm);
        return {d, 8'h00, ch, 1'b0, clr, sw, arm};
    endfunction

    function automatic logic [VEC_W-1:0] dut_vec();
        return {sync_out, armed, chan_sel, fine_delay, sync_count};
    endfunction

    function automatic logic [VEC_W-1:0] model_vec();
        return {m_sync, m_armed, m_chan, m_delay, m_count};
    endfunction

    task automatic model_edge();
        logic arm_r, arm_f, sw_r, clr_r;
        cyc++;
        if (rst) begin
            phase = 0; fire_at = -10; c1 = '0; c2 = '0;
            m_chan = '0; m_delay = '0; m_count = '0; m_sync = 1'b0; m_armed = 1'b0;
        end else begin
            arm_r = c1[0] & ~c2[0];
            arm_f = ~c1[0] & c2[0];
            sw_r  = c1[1] & ~c2[1];
            clr_r = c1[2] & ~c2[2];
            if (phase == 2 && fire_at == cyc - 1) begin
                m_count++;
                phase = 0;
            end else if (phase == 2) begin
                if (arm_f) phase = 0;
            end else if (phase == 1) begin
                if (arm_f) phase = 0;
                else if (sync_in || sw_r) begin
                    phase = 2;
                    fire_at = cyc + int'(m_delay);
                end
            end else if (arm_r) begin
                phase = 1;
                m_chan = c1[7:4];
                m_delay = c1[31:16];
            end
            if (clr_r) m_count = '0;
            m_sync  = (phase == 2) && (fire_at == cyc);
            m_armed = (phase == 1) || (phase == 2 && fire_at > cyc);
            c2 = c1;
            c1 = ctrl_word;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ctrl_word = '0; sync_in = 1'b0;
        repeat (3) step();
        n_checks++;
        if (dut_vec() !== '0) begin
            n_fail++; $display("FAIL reset_hold got=%h exp=0", dut_vec());
        end
        rst = 1'b0;
        repeat (2) step();
        n_checks++;
        if (dut_vec() !== model_vec() || dut_vec() !== '0) begin
            n_fail++; $display("FAIL reset_release got=%h exp=%h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_zero_delay();
        logic [CNT_W-1:0] base;
        ctrl_word = '0; sync_in = 1'b0;
        repeat (3) step();
        base = m_count;
        for (int k = 0; k < 5; k++) begin
            case (k)
                0: ctrl_word = mk(16'd0, 4'h3, 1'b0, 1'b0, 1'b1);
                2: sync_in = 1'b1;
                3: sync_in = 1'b0;
                default: ;
            endcase
            step();
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL zero_delay_model k=%0d got=%h exp=%h", k, dut_vec(), model_vec());
            end
            n_checks++;
            if (sync_out !== 1'(k == 2) || armed !== 1'(k == 1)) begin
                n_fail++; $display("FAIL zero_delay_pulse k=%0d got sync_out=%b armed=%b", k, sync_out, armed);
            end
        end
        n_checks++;
        if (sync_count !== CNT_W'(base + 1'b1) || chan_sel !== 4'h3) begin
            n_fail++; $display("FAIL zero_delay_count got=%0d exp=%0d chan=%h", sync_count, CNT_W'(base + 1'b1), chan_sel);
        end
        ctrl_word = '0;
        repeat (2) step();
    endtask

    task automatic test_delay5_swtrig();
        for (int k = 0; k < 12; k++) begin
            case (k)
                0: ctrl_word = mk(16'd5, 4'h5, 1'b0, 1'b0, 1'b1);
                2: ctrl_word = mk(16'd5, 4'h5, 1'b0, 1'b1, 1'b1);
                5: sync_in = 1'b1;
                6: sync_in = 1'b0;
                default: ;
            endcase
            step();
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL delay5_model k=%0d got=%h exp=%h", k, dut_vec(), model_vec());
            end
            n_checks++;
            if (sync_out !== 1'(k == 8) || armed !== 1'(k >= 1 && k < 8)) begin
                n_fail++; $display("FAIL delay5_timing k=%0d got sync_out=%b armed=%b", k, sync_out, armed);
            end
        end
        n_checks++;
        if (fine_delay !== 16'd5 || chan_sel !== 4'h5) begin
            n_fail++; $display("FAIL delay5_fields got delay=%0d chan=%h exp 5/5", fine_delay, chan_sel);
        end
        ctrl_word = '0;
        repeat (2) step();
    endtask

    task automatic test_disarm();
        logic [CNT_W-1:0] base;
        base = m_count;
        for (int k = 0; k < 51; k++) begin
            case (k)
                0:  ctrl_word = mk(16'd100, 4'h9, 1'b0, 1'b0, 1'b1);
                2:  sync_in = 1'b1;
                3:  sync_in = 1'b0;
                42: ctrl_word = mk(16'd100, 4'h9, 1'b0, 1'b0, 1'b0);
                default: ;
            endcase
            step();
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL disarm_model k=%0d got=%h exp=%h", k, dut_vec(), model_vec());
            end
            n_checks++;
            if (sync_out !== 1'b0 || armed !== 1'(k >= 1 && k < 43)) begin
                n_fail++; $display("FAIL disarm_timing k=%0d got sync_out=%b armed=%b", k, sync_out, armed);
            end
        end
        n_checks++;
        if (sync_count !== base || fine_delay !== 16'd100) begin
            n_fail++; $display("FAIL disarm_count got=%0d exp=%0d delay=%0d", sync_count, base, fine_delay);
        end
    endtask

    task automatic test_reset_mid_delay();
        ctrl_word = '0; sync_in = 1'b0;
        repeat (2) step();
        for (int k = 0; k < 16; k++) begin
            case (k)
                0: ctrl_word = mk(16'd20, 4'h6, 1'b0, 1'b0, 1'b1);
                2: sync_in = 1'b1;
                3: sync_in = 1'b0;
                6: begin rst = 1'b1; ctrl_word = mk(16'd7, 4'hA, 1'b0, 1'b0, 1'b1); end
                7: rst = 1'b0;
                default: ;
            endcase
            step();
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL rst_delay_model k=%0d got=%h exp=%h", k, dut_vec(), model_vec());
            end
            n_checks++;
            if (sync_out !== 1'b0) begin
                n_fail++; $display("FAIL rst_delay_pulse k=%0d got sync_out=%b exp=0", k, sync_out);
            end
            if (k == 6 || k == 7) begin
                n_checks++;
                if (dut_vec() !== '0) begin
                    n_fail++; $display("FAIL rst_delay_zero k=%0d got=%h exp=0", k, dut_vec());
                end
            end
            if (k == 8) begin
                n_checks++;
                if (armed !== 1'b1 || chan_sel !== 4'hA || fine_delay !== 16'd7) begin
                    n_fail++; $display("FAIL rst_delay_rearm got armed=%b chan=%h delay=%0d exp 1/a/7", armed, chan_sel, fine_delay);
                end
            end
        end
        ctrl_word = '0;
        repeat (3) step();
    endtask

    task automatic test_wrap_and_clr();
        int iter;
        int fires_after;
        iter = 0;
        fires_after = 0;
        ctrl_word = '0; sync_in = 1'b0;
        repeat (2) step();
        while ((m_count != {CNT_W{1'b1}} || fires_after > 0) && iter < 600 && fires_after < 3) begin
            if (m_count == {CNT_W{1'b1}} || fires_after > 0) fires_after++;
            for (int k = 0; k < 4; k++) begin
                case (k)
                    0: ctrl_word = mk(16'd0, 4'h1, 1'b0, 1'b0, 1'b1);
                    2: begin
                        sync_in = 1'b1;
                        if (fires_after == 3) ctrl_word = mk(16'd0, 4'h1, 1'b1, 1'b0, 1'b1);
                    end
                    3: begin sync_in = 1'b0; ctrl_word = '0; end
                    default: ;
                endcase
                step();
                n_checks++;
                if (dut_vec() !== model_vec()) begin
                    n_fail++; $display("FAIL wrap_model iter=%0d k=%0d got=%h exp=%h", iter, k, dut_vec(), model_vec());
                end
            end
            if (fires_after == 0 && m_count == {CNT_W{1'b1}}) begin
                n_checks++;
                if (sync_count !== {CNT_W{1'b1}}) begin
                    n_fail++; $display("FAIL wrap_max got=%0d exp=%0d", sync_count, {CNT_W{1'b1}});
                end
                fires_after = 1;
            end else if (fires_after == 1) begin
                n_checks++;
                if (sync_count !== '0) begin
                    n_fail++; $display("FAIL wrap_zero got=%0d exp=0", sync_count);
                end
                fires_after = 2;
            end else if (fires_after == 3) begin
                n_checks++;
                if (sync_count !== '0) begin
                    n_fail++; $display("FAIL clr_vs_fire got=%0d exp=0", sync_count);
                end
            end
            iter++;
        end
        n_checks++;
        if (iter >= 600) begin
            n_fail++; $display("FAIL wrap_budget got iter=%0d exp <600", iter);
        end
        repeat (2) step();
    endtask

    task automatic test_random();
        logic [31:0] cw;
        cw = '0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(7) == 0)  cw[0] = ~cw[0];
            if ($urandom_range(3) == 0)  cw[1] = ~cw[1];
            if ($urandom_range(15) == 0) cw[2] = ~cw[2];
            cw[7:4]   = 4'($urandom_range(15));
            cw[31:16] = 16'($urandom_range(6));
            ctrl_word = cw;
            sync_in   = ($urandom_range(4) == 0);
            rst       = ($urandom_range(249) == 0);
            step();
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL random i=%0d got=%h exp=%h", i, dut_vec(), model_vec());
            end
        end
        rst = 1'b0; sync_in = 1'b0; ctrl_word = '0;
        repeat (2) step();
    endtask

    initial begin
        test_reset();
        test_zero_delay();
        test_delay5_swtrig();
        test_disarm();
        test_reset_mid_delay();
        test_wrap_and_clr();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fine_ctrl_sync_arm.md
FINE_CTRL_SYNC_ARM -- requirements
Module: fine_ctrl_sync_arm

Interface
REQ-001 SHALL have parameter DELAY_W, default 16, width of the fine-delay field and down-counter.
REQ-002 SHALL have parameter CNT_W, default 16, width of the fired-sync counter.
REQ-003 SHALL have port user_clk  in  1  the single clock; all logic is rising-edge, no other clock.
REQ-004 SHALL have port user_rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port ctrl_word  in  32  control word from the fine_ctrl software register (user_data_out), fields: bit0 arm, bit1 sw_trig, bit2 cnt_clr, bits7:4 chan_sel, bits31:16 fine_delay.
REQ-006 SHALL have port sync_in  in  1  pipeline sync pulse; any cycle high counts as an event.
REQ-007 SHALL have port sync_out  out  1  one-cycle delayed sync pulse to the downstream datapath.
REQ-008 SHALL have port armed  out  1  high in states ARMED and DELAY.
REQ-009 SHALL have port chan_sel  out  4  channel select latched at arm.
REQ-010 SHALL have port fine_delay  out  DELAY_W  delay value latched at arm.
REQ-011 SHALL have port sync_count  out  CNT_W  number of sync_out pulses issued, for a readback register.

Function
REQ-012 SHALL register ctrl_word once (ctrl_q) and again (ctrl_qq); edges = ctrl_q vs ctrl_qq, per bit for arm, sw_trig, cnt_clr.
REQ-013 SHALL implement states IDLE, ARMED, DELAY, FIRE.
REQ-014 IDLE: arm rising edge -> ARMED; latch chan_sel and fine_delay from ctrl_q in the same cycle; armed high 2 cycles after ctrl_word bit0 goes 0->1.
REQ-015 ARMED: event = sync_in high OR sw_trig rising edge; on event with latched delay D=0 -> FIRE, else -> DELAY with counter loaded to D.
REQ-016 DELAY: counter decrements each cycle; counter==1 -> FIRE.
REQ-017 FIRE: sync_out high for exactly this one cycle, then -> IDLE; sync_out thus rises exactly D+1 cycles after the event cycle.
REQ-018 Arm falling edge in ARMED or DELAY SHALL -> IDLE without sync_out; disarm wins over a simultaneous event.
REQ-019 Arm rising edge outside IDLE SHALL be ignored; latched fields SHALL not change outside the IDLE->ARMED transition.
REQ-020 sync_in or sw_trig in IDLE, DELAY or FIRE SHALL be ignored (no retrigger, no counter reload).
REQ-021 sync_count SHALL increment on every FIRE cycle, wrapping 2^CNT_W-1 -> 0.
REQ-022 cnt_clr rising edge SHALL zero sync_count; on simultaneous FIRE clear wins and the pulse is not counted.
REQ-023 Re-arm SHALL require arm to return low then high again (edge-driven, level alone never re-arms).

Reset
REQ-024 On user_rst high: state IDLE, sync_out 0, armed 0, chan_sel 0, fine_delay 0, sync_count 0, delay counter 0, ctrl_q and ctrl_qq 0.
REQ-025 Reset mid-DELAY SHALL abort with no sync_out; ctrl_word bit0 held high through reset release SHALL produce one arm edge 1 cycle after reset deasserts (ctrl_q goes 0->1).

Structure
REQ-026 Shared package fine_ctrl_pkg SHALL hold the state enum, ctrl_word bit/field index constants and default widths.
REQ-027 One sub-module fine_ctrl_edge_det (registered rising/falling edge detector, parameterised width) SHALL be used for the three control bits.

Verification
REQ-028 Arm with fine_delay=0, sync_in pulse at cycle T -> sync_out only at T+1, sync_count=1, armed low at T+1.
REQ-029 Arm with fine_delay=5, sw_trig rising edge -> sync_out exactly 6 cycles after edge detection; second sync_in during DELAY has no effect.
REQ-030 Arm with fine_delay=100, clear arm bit after 40 cycles of DELAY -> no sync_out, state IDLE, sync_count unchanged.
REQ-031 sync_count preloaded to 0xFFFF via 65535 fires (or forced), one more fire -> 0x0000; cnt_clr edge coincident with FIRE -> sync_count 0.
REQ-032 Assert user_rst for 1 cycle during DELAY with arm bit held high -> all outputs 0, no sync_out, armed re-asserts 2 cycles after reset release with newly latched fields.
